// File: rtl/keychain_pkg.sv
// Shared constants, state encoding and small helpers for the keychain
// command sequencer. Optional feature macro: KEYCHAIN_CMD_CHECKSUM_EN.
package keychain_pkg;

    localparam logic [7:0] OP_KEY  = 8'h4B;  // 'K' load key
    localparam logic [7:0] OP_ENC  = 8'h45;  // 'E' encrypt
    localparam logic [7:0] OP_STAT = 8'h53;  // 'S' status
    localparam logic [7:0] ACK     = 8'h06;
    localparam logic [7:0] NAK     = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        RX_KEY,
        RX_MSG,
        START,
        WAIT_CORE,
        TX_RESULT,
        TX_BYTE
    } ctrl_state_t;

    // Add up to three error events to the counter without wrapping past 255.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] n);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'b0, n};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // Error count clipped to the seven bits available in the status byte.
    function automatic logic [6:0] err_sat7(input logic [7:0] e);
        return e[7] ? 7'h7F : e[6:0];
    endfunction

endpackage

// File: rtl/keychain_cmd_ctrl_if.sv
// Byte-stream and cipher-core signals of the command sequencer.
// master = the sequencer, slave = the UART engines and cipher core around it.
interface keychain_cmd_ctrl_if #(
    parameter int KEY_BYTES = 2,
    parameter int MSG_BYTES = 1
);
    logic [7:0]             rx_data_in;
    logic                   rx_valid_in;
    logic [7:0]             tx_data_out;
    logic                   tx_valid_out;
    logic                   tx_ready_in;
    logic [8*KEY_BYTES-1:0] key_out;
    logic [8*MSG_BYTES-1:0] msg_out;
    logic                   start_out;
    logic                   core_busy_in;
    logic [8*MSG_BYTES-1:0] result_in;
    logic                   result_valid_in;
    logic                   key_loaded_out;
    logic [7:0]             err_count_out;

    modport master (
        input  rx_data_in, rx_valid_in, tx_ready_in, core_busy_in, result_in, result_valid_in,
        output tx_data_out, tx_valid_out, key_out, msg_out, start_out, key_loaded_out, err_count_out
    );

    modport slave (
        output rx_data_in, rx_valid_in, tx_ready_in, core_busy_in, result_in, result_valid_in,
        input  tx_data_out, tx_valid_out, key_out, msg_out, start_out, key_loaded_out, err_count_out
    );
endinterface

// File: rtl/keychain_timeout.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and
// strobes expired on the TIMEOUT_CYCLES-th one. A clear in the same cycle wins.
module keychain_timeout #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int               CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]    LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Count idle cycles while enabled; restart on clear, disable or expiry.
    always_ff @(posedge clk_in) begin
        if (rst_in || clear || !enable || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/keychain_cmd_ctrl.sv
// Command sequencer between the UART byte engines and the keychain cipher core.
// Parses 'K'/'E'/'S' frames, loads key/message, runs the core and answers
// with result, ACK or NAK bytes.
// Optional feature macro: KEYCHAIN_CMD_CHECKSUM_EN (XOR checksum byte on
// 'K'/'E' frames and on result responses, with shadow-staged payloads).
module keychain_cmd_ctrl
    import keychain_pkg::*;
#(
    parameter int KEY_BYTES      = 2,
    parameter int MSG_BYTES      = 1,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                clk_in,
    input  logic                rst_in,
    keychain_cmd_ctrl_if.master bus
);
    localparam int KW        = 8 * KEY_BYTES;
    localparam int MW        = 8 * MSG_BYTES;
    localparam int MAX_BYTES = (KEY_BYTES > MSG_BYTES) ? KEY_BYTES : MSG_BYTES;
`ifdef KEYCHAIN_CMD_CHECKSUM_EN
    localparam int CNT_W     = $clog2(MAX_BYTES + 2);
    localparam int KEY_LAST  = KEY_BYTES;      // trailing checksum byte
    localparam int MSG_LAST  = MSG_BYTES;
    localparam int RES_LAST  = MSG_BYTES;      // result bytes plus checksum
`else
    localparam int CNT_W     = $clog2(MAX_BYTES + 1);
    localparam int KEY_LAST  = KEY_BYTES - 1;
    localparam int MSG_LAST  = MSG_BYTES - 1;
    localparam int RES_LAST  = MSG_BYTES - 1;
`endif

    ctrl_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [KW-1:0]   key_q;
    logic [MW-1:0]   msg_q;
    logic [MW-1:0]   res_q;
    logic [7:0]      tx_data_q;
    logic            tx_valid_q;
    logic            start_q;
    logic            key_loaded_q;
    logic [7:0]      err_q;

    logic [7:0] rx_byte;
    logic       rx;
    logic       tx_fire;
    logic       overrun;
    logic       proto_err;
    logic       frame_ok;
    logic       key_last;
    logic       msg_last;
    logic       to_clear;
    logic       to_enable;
    logic       expired;

    assign rx_byte  = bus.rx_data_in;
    assign rx       = bus.rx_valid_in;
    assign tx_fire  = tx_valid_q && bus.tx_ready_in;
    assign key_last = (cnt == CNT_W'(KEY_LAST));
    assign msg_last = (cnt == CNT_W'(MSG_LAST));
    assign overrun  = rx && (state inside {START, WAIT_CORE, TX_RESULT, TX_BYTE});

    // The watchdog only runs while waiting on the host or the core; outside
    // those states it is held clear so each timed state starts from zero.
    assign to_enable = (state inside {RX_KEY, RX_MSG, WAIT_CORE});
    assign to_clear  = rx && (state inside {RX_KEY, RX_MSG});

    keychain_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .clear   (to_clear),
        .enable  (to_enable),
        .expired (expired)
    );

`ifdef KEYCHAIN_CMD_CHECKSUM_EN
    logic [KW-1:0] key_sh;
    logic [MW-1:0] msg_sh;
    logic [7:0]    csum;
    logic [7:0]    res_csum;
    logic [7:0]    result_xor;

    assign frame_ok = (csum == rx_byte);

    // XOR of all result bytes, appended after the result on the TX side.
    always_comb begin
        result_xor = 8'h00;
        for (int i = 0; i < MSG_BYTES; i++) begin
            result_xor = result_xor ^ bus.result_in[8*i +: 8];
        end
    end
`else
    assign frame_ok = 1'b1;
`endif

    // Single-cycle protocol errors detected by the current state.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        proto_err = 1'b0;
        case (state)
            IDLE:      proto_err = rx && !(rx_byte inside {OP_KEY, OP_ENC, OP_STAT});
            RX_KEY:    proto_err = rx ? (key_last && !frame_ok) : expired;
            RX_MSG:    proto_err = rx ? (msg_last && (!frame_ok || !key_loaded_q)) : expired;
            WAIT_CORE: proto_err = !bus.result_valid_in && expired;
            default:   proto_err = 1'b0;
        endcase
    end

    // Sequencer FSM with registered outputs and saturating error counter.
    // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= IDLE;
            cnt          <= '0;
            key_q        <= '0;
            msg_q        <= '0;
            res_q        <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            start_q      <= 1'b0;
            key_loaded_q <= 1'b0;
            err_q        <= '0;
`ifdef KEYCHAIN_CMD_CHECKSUM_EN
            key_sh       <= '0;
            msg_sh       <= '0;
            csum         <= '0;
            res_csum     <= '0;
`endif
        end else begin
            err_q   <= sat_add8(err_q, {1'b0, overrun} + {1'b0, proto_err});
            start_q <= 1'b0;  // pulse unless START re-arms it below

            case (state)
                IDLE: begin
                    if (rx) begin
                        cnt <= '0;
`ifdef KEYCHAIN_CMD_CHECKSUM_EN
                        csum <= rx_byte;
`endif
                        case (rx_byte)
                            OP_KEY:  state <= RX_KEY;
                            OP_ENC:  state <= RX_MSG;
                            OP_STAT: begin
                                tx_data_q  <= {key_loaded_q, err_sat7(err_q)};
                                tx_valid_q <= 1'b1;
                                state      <= TX_BYTE;
                            end
                            default: begin
                                tx_data_q  <= NAK;
                                tx_valid_q <= 1'b1;
                                state      <= TX_BYTE;
                            end
                        endcase
                    end
                end

                RX_KEY: begin
                    if (rx) begin
                        cnt <= cnt + CNT_W'(1);
`ifdef KEYCHAIN_CMD_CHECKSUM_EN
                        csum <= csum ^ rx_byte;
                        if (!key_last) key_sh[8*(KEY_BYTES-1-int'(cnt)) +: 8] <= rx_byte;
`else
                        key_q[8*(KEY_BYTES-1-int'(cnt)) +: 8] <= rx_byte;
`endif
                        if (key_last) begin
                            tx_valid_q <= 1'b1;
                            state      <= TX_BYTE;
                            if (frame_ok) begin
                                key_loaded_q <= 1'b1;
                                tx_data_q    <= ACK;
`ifdef KEYCHAIN_CMD_CHECKSUM_EN
                                key_q        <= key_sh;
`endif
                            end else begin
                                tx_data_q <= NAK;
                            end
                        end
                    end else if (expired) begin
                        state <= IDLE;
                    end
                end

                RX_MSG: begin
                    if (rx) begin
                        cnt <= cnt + CNT_W'(1);
`ifdef KEYCHAIN_CMD_CHECKSUM_EN
                        csum <= csum ^ rx_byte;
                        if (!msg_last) msg_sh[8*(MSG_BYTES-1-int'(cnt)) +: 8] <= rx_byte;
`else
                        msg_q[8*(MSG_BYTES-1-int'(cnt)) +: 8] <= rx_byte;
`endif
                        if (msg_last) begin
                            if (frame_ok && key_loaded_q) begin
`ifdef KEYCHAIN_CMD_CHECKSUM_EN
                                msg_q   <= msg_sh;
`endif
                                start_q <= !bus.core_busy_in;
                                state   <= START;
                            end else begin
                                tx_data_q  <= NAK;
                                tx_valid_q <= 1'b1;
                                state      <= TX_BYTE;
                            end
                        end
                    end else if (expired) begin
                        state <= IDLE;
                    end
                end

                START: begin
                    if (start_q) begin
                        state <= WAIT_CORE;
                    end else if (!bus.core_busy_in) begin
                        start_q <= 1'b1;
                    end
                end

                WAIT_CORE: begin
                    if (bus.result_valid_in) begin
                        tx_data_q  <= bus.result_in[MW-1 -: 8];
                        res_q      <= bus.result_in << 8;
                        tx_valid_q <= 1'b1;
                        cnt        <= '0;
`ifdef KEYCHAIN_CMD_CHECKSUM_EN
                        res_csum   <= result_xor;
`endif
                        state      <= TX_RESULT;
                    end else if (expired) begin
                        tx_data_q  <= NAK;
                        tx_valid_q <= 1'b1;
                        state      <= TX_BYTE;
                    end
                end

                TX_RESULT: begin
                    if (tx_fire) begin
                        if (cnt == CNT_W'(RES_LAST)) begin
                            tx_valid_q <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            cnt   <= cnt + CNT_W'(1);
                            res_q <= res_q << 8;
`ifdef KEYCHAIN_CMD_CHECKSUM_EN
                            tx_data_q <= (cnt == CNT_W'(MSG_BYTES - 1)) ? res_csum : res_q[MW-1 -: 8];
`else
                            tx_data_q <= res_q[MW-1 -: 8];
`endif
                        end
                    end
                end

                TX_BYTE: begin
                    if (tx_fire) begin
                        tx_valid_q <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_data_out    = tx_data_q;
    assign bus.tx_valid_out   = tx_valid_q;
    assign bus.key_out        = key_q;
    assign bus.msg_out        = msg_q;
    assign bus.start_out      = start_q;
    assign bus.key_loaded_out = key_loaded_q;
    assign bus.err_count_out  = err_q;

endmodule

// File: doc/keychain_cmd_ctrl.md
Name: keychain_cmd_ctrl

Overview:
- Command sequencer between the UART byte interface and the keychain cipher core.
- Parses opcode frames from the RX byte stream and loads the key or message registers.
- Starts the core, waits for its result, and returns result, ACK or NAK bytes through the TX byte handshake.
- Sits inside keychain, between the UART RX/TX byte engines and the cipher datapath.

Parameters:
- KEY_BYTES, 2: key length in bytes.
- MSG_BYTES, 1: message/result length in bytes.
- TIMEOUT_CYCLES, 1_000_000: inter-byte and core-completion timeout, in clk_in cycles.

Ports:
- clk_in  input  1  system clock (single clock domain)
- rst_in  input  1  synchronous, active-high reset
- rx_data_in  input  8  received byte
- rx_valid_in  input  1  one-cycle strobe, rx_data_in valid
- tx_data_out  output  8  byte to transmit
- tx_valid_out  output  1  tx_data_out valid; held until accepted
- tx_ready_in  input  1  TX engine can accept; transfer when valid&ready
- key_out  output  8*KEY_BYTES  key register to core
- msg_out  output  8*MSG_BYTES  message register to core
- start_out  output  1  one-cycle pulse, core begins operation
- core_busy_in  input  1  core is busy
- result_in  input  8*MSG_BYTES  core result
- result_valid_in  input  1  one-cycle strobe, result_in valid
- key_loaded_out  output  1  a full key has been loaded since reset
- err_count_out  output  8  saturating error counter

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0; byte counter, timeout counter and key_loaded cleared.
- Opcodes:
  - 'K' (0x4B) = load key, followed by KEY_BYTES bytes.
  - 'E' (0x45) = encrypt, followed by MSG_BYTES bytes.
  - 'S' (0x53) = status.
- Responses: ACK = 0x06, NAK = 0x15.
- Payload byte order: first received byte lands in the MSB lane; result is transmitted MSB byte first.
- States: IDLE, RX_KEY, RX_MSG, START, WAIT_CORE, TX_RESULT, TX_BYTE.
- IDLE:
  - 'K' -> RX_KEY.
  - 'E' -> RX_MSG.
  - 'S' -> TX_BYTE with {key_loaded, err_sat7}; err_sat7 = min(err_count, 127).
  - Any other byte -> TX_BYTE with NAK, err +1.
- RX_KEY: shift bytes into key_out. After byte KEY_BYTES: key_loaded <= 1, then TX_BYTE with ACK. key_out updates byte-by-byte during load.
- RX_MSG: shift bytes into msg_out. After byte MSG_BYTES: -> START if key_loaded, else TX_BYTE with NAK and err +1.
- START: wait for core_busy_in == 0, then assert start_out for exactly one cycle -> WAIT_CORE.
- WAIT_CORE: on result_valid_in, capture result_in -> TX_RESULT.
- TX_RESULT: emit MSG_BYTES bytes, one per valid&ready transfer -> IDLE.
- TX_BYTE: emit one byte -> IDLE.
- Latency:
  - tx_valid_out rises the cycle after the final frame byte's rx_valid_in.
  - start_out rises the cycle after the last message byte (if core idle).
- Timeout counter:
  - Runs in RX_KEY, RX_MSG and WAIT_CORE; clears on every accepted byte and on state entry.
  - Reaching TIMEOUT_CYCLES in RX_KEY/RX_MSG: discard the partial frame, -> IDLE, err +1, no response. A partial key does not change key_loaded.
  - Reaching TIMEOUT_CYCLES in WAIT_CORE: TX_BYTE with NAK, err +1.
  - rx_valid_in in the same cycle as expiry: byte accepted, timeout does not fire.
- Bytes arriving in START, WAIT_CORE, TX_RESULT or TX_BYTE are dropped, err +1 each (overrun).
- err_count_out saturates at 255 and never wraps.
- tx_data_out must remain stable while tx_valid_out=1 and tx_ready_in=0.
- Reset asserted mid-frame or mid-transmit aborts immediately; key_loaded clears.

Optional Feature:
- Macro KEYCHAIN_CMD_CHECKSUM_EN.
- Defined:
  - 'K' and 'E' frames carry one trailing checksum byte = XOR of opcode and all payload bytes.
  - Mismatch -> NAK, err +1; the key/message is not committed (staged in a shadow register).
  - Responses to 'E' append an XOR checksum byte of the result bytes.
- Undefined: no checksum bytes in either direction; the shadow register is absent.

Decomposition:
- Package keychain_pkg holds:
  - opcode constants OP_KEY, OP_ENC, OP_STAT;
  - ACK/NAK constants;
  - the state enum typedef ctrl_state_t.
- Sub-module keychain_timeout (clear, enable, expired strobe; parameter TIMEOUT_CYCLES) is natural; counter width $clog2(TIMEOUT_CYCLES+1).
- Byte counter width: $clog2(max(KEY_BYTES, MSG_BYTES)+1).

Test Plan (KEY_BYTES=2, MSG_BYTES=1, TIMEOUT_CYCLES=100, tx_ready_in=1 unless stated):
- 0x4B,0xA5,0x3C -> key_out=0xA53C, key_loaded_out=1, TX 0x06.
- After key load: 0x45,0x11; core returns 0x7E -> one start_out pulse, msg_out=0x11, TX 0x7E.
- After reset: 0x45,0x11 -> no start_out, TX 0x15, err_count_out=1. Then 0x53 -> TX 0x01.
- 0x4B,0xA5, then 100 idle cycles -> no TX, state IDLE, err_count_out=1, key_out upper byte 0xA5 but key_loaded_out=0.
- tx_ready_in=0 for 20 cycles during the ACK -> tx_valid_out held, tx_data_out=0x06 stable. Extra byte 0x99 arriving meanwhile -> dropped, err +1.
- 300 bytes of 0xFF -> 300 NAKs; err_count_out saturates at 255.
